// File: rtl/toggle_monitor.sv
// Watches the toggling output of an upstream T flip-flop and reports transition count,
// inter-transition period, per-transition pulse, stall and count-overflow status.
//
// state      | meaning
// IDLE       | monitor disabled; q_prev still tracks Q so re-enable never sees a stale edge
// WAIT_FIRST | enabled, no transition yet; transitions count but do not set period
// RUN        | transitions arriving; each one updates count and period
// STALL      | no transition for STALL_LIMIT enabled cycles
module toggle_monitor #(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic       Q,
  output logic [7:0] count,
  output logic [7:0] period,
  output logic       edge_pulse,
  output logic       stall,
  output logic       ovf,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2,
    STALL      = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  state_t     st;
  logic       q_prev;
  logic [7:0] gap;
  logic       toggled;
  logic [7:0] gap_inc;
  logic [8:0] gap_p1;
  logic [7:0] period_next;

  assign toggled     = (Q != q_prev) && (st != IDLE);
  assign gap_inc     = (gap == 8'hFF) ? gap : gap + 8'd1;
  assign gap_p1      = {1'b0, gap} + 9'd1;
  assign period_next = gap_p1[8] ? 8'hFF : gap_p1[7:0];
  assign state       = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      q_prev     <= 1'b0;
      gap        <= 8'd0;
      count      <= 8'd0;
      period     <= 8'd0;
      edge_pulse <= 1'b0;
      stall      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      q_prev <= Q;
      if (clear) begin
        count      <= 8'd0;
        period     <= 8'd0;
        gap        <= 8'd0;
        ovf        <= 1'b0;
        edge_pulse <= 1'b0;
        stall      <= 1'b0;
        st         <= enable ? WAIT_FIRST : IDLE;
      end else if (!enable) begin
        edge_pulse <= 1'b0;
        stall      <= 1'b0;
        st         <= IDLE;
      end else if (st == IDLE) begin
        // first enabled cycle only primes q_prev
        edge_pulse <= 1'b0;
        stall      <= 1'b0;
        st         <= WAIT_FIRST;
      end else if (toggled) begin
        count <= count + 8'd1;
        if (count == 8'hFF) ovf <= 1'b1;
        if (st != WAIT_FIRST) period <= period_next;
        gap        <= 8'd0;
        edge_pulse <= 1'b1;
        stall      <= 1'b0;
        st         <= RUN;
      end else begin
        gap        <= gap_inc;
        edge_pulse <= 1'b0;
        if (gap_inc >= LIMIT) begin
          st    <= STALL;
          stall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Scoreboard bench for toggle_monitor: directed scenarios plus randomized traffic,
// expected outputs from an integer-level reference model.
module tb_toggle_monitor;

  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       Q;
  logic [7:0] count;
  logic [7:0] period;
  logic       edge_pulse;
  logic       stall;
  logic       ovf;
  logic [1:0] state;

  toggle_monitor #(.STALL_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .Q          (Q),
    .count      (count),
    .period     (period),
    .edge_pulse (edge_pulse),
    .stall      (stall),
    .ovf        (ovf),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] count;
    logic [7:0] period;
    logic       edge_pulse;
    logic       stall;
    logic       ovf;
    logic [1:0] state;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   qv;

  // model: transitions since clear, enabled quiet cycles since last transition
  int m_total, m_quiet, m_per, m_mode;
  bit m_edge, m_qp;

  function automatic void model_reset();
    m_total = 0; m_quiet = 0; m_per = 0; m_mode = 0; m_edge = 0; m_qp = 0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.count      = 8'(m_total % 256);
    o.period     = 8'(m_per);
    o.edge_pulse = m_edge;
    o.stall      = (m_mode == 3);
    o.ovf        = (m_total >= 256);
    o.state      = 2'(m_mode);
    return o;
  endfunction

  function automatic void model_step(bit en, bit clr, bit q);
    bit moved;
    moved = (q != m_qp) && (m_mode != 0);
    m_qp  = q;
    if (clr) begin
      m_total = 0; m_per = 0; m_quiet = 0; m_edge = 0;
      m_mode  = en ? 1 : 0;
    end else if (!en) begin
      m_edge = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      m_edge = 0; m_mode = 1;
    end else if (moved) begin
      if (m_mode != 1) m_per = (m_quiet + 1 > 255) ? 255 : m_quiet + 1;
      m_total++;
      m_quiet = 0; m_edge = 1; m_mode = 2;
    end else begin
      m_quiet++;
      m_edge = 0;
      if (m_quiet >= LIMIT) m_mode = 3;
    end
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("cnt=%0d per=%0d edge=%0b stall=%0b ovf=%0b st=%0d",
                     o.count, o.period, o.edge_pulse, o.stall, o.ovf, o.state);
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o = {count, period, edge_pulse, stall, ovf, state};
    return o;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // apply one cycle of stimulus, queue its expected result, return after the edge
  task automatic drive(bit en, bit clr, bit tog);
    qv     = qv ^ tog;
    enable = en;
    clear  = clr;
    Q      = qv;
    model_step(en, clr, qv);
    exp_q.push_back(model_obs());
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    chk("reset async outputs", int'(cur()), 0);
    model_reset();
    @(negedge clk);
    #1;
    chk("reset held outputs", int'(cur()), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    Q      = 1'b0;
    qv     = 1'b0;
    model_reset();

    fork
      forever begin : monitor
        obs_t e;
        obs_t a;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = cur();
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL cycle %0d outputs: got %s expected %s", cyc, fmt(a), fmt(e));
          end
        end
      end
    join_none

    @(negedge clk);
    #1;
    chk("power-up reset outputs", int'(cur()), 0);
    reset = 1'b0;

    // Q=1 at the first enabled edge only primes
    qv = 1'b1;
    drive(1, 0, 0);
    chk("prime state", int'(state), 1);
    chk("prime count", int'(count), 0);

    for (int i = 0; i < 10; i++) drive(1, 0, 1);
    chk("free-run count", int'(count), 10);
    chk("free-run period", int'(period), 1);
    chk("free-run state", int'(state), 2);
    chk("free-run edge", int'(edge_pulse), 1);

    for (int r = 0; r < 3; r++) begin
      drive(1, 0, 1);
      for (int i = 0; i < 3; i++) drive(1, 0, 0);
    end
    chk("toggle/4 period", int'(period), 4);
    chk("toggle/4 stall", int'(stall), 0);

    drive(1, 0, 1);
    for (int i = 0; i < LIMIT; i++) drive(1, 0, 0);
    chk("stall flag", int'(stall), 1);
    chk("stall state", int'(state), 3);
    drive(1, 0, 1);
    chk("unstall flag", int'(stall), 0);
    chk("unstall period", int'(period), LIMIT + 1);

    drive(1, 1, 0);
    for (int i = 0; i < 300; i++) drive(1, 0, 1);
    chk("wrap count", int'(count), 44);
    chk("wrap ovf", int'(ovf), 1);
    drive(1, 1, 0);
    chk("clear count", int'(count), 0);
    chk("clear ovf", int'(ovf), 0);
    chk("clear period", int'(period), 0);

    for (int i = 0; i < 5; i++) drive(1, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, 1);
    chk("disabled count", int'(count), 5);
    chk("disabled period", int'(period), 1);
    chk("disabled state", int'(state), 0);
    drive(1, 0, 1);
    chk("re-enable edge", int'(edge_pulse), 0);
    chk("re-enable count", int'(count), 5);
    drive(1, 0, 1);
    chk("resume edge", int'(edge_pulse), 1);
    chk("resume count", int'(count), 6);

    drive(1, 0, 1);
    chk("pre-reset count", int'(count), 7);
    chk("pre-reset state", int'(state), 2);
    pulse_reset();

    qv = 1'b1;
    drive(1, 0, 0);
    chk("post-reset state", int'(state), 1);
    chk("post-reset count", int'(count), 0);

    // gap saturation: long quiet interval gives period 255
    drive(1, 0, 1);
    for (int i = 0; i < 300; i++) drive(1, 0, 0);
    drive(1, 0, 1);
    chk("saturated period", int'(period), 255);
    chk("saturated state", int'(state), 2);

    for (int s = 0; s < 150; s++) begin
      int len;
      int pt;
      len = $urandom_range(1, 40);
      case ($urandom_range(0, 4))
        0: pt = 0;
        1: pt = 25;
        2: pt = 50;
        3: pt = 100;
        default: begin pt = 0; len = $urandom_range(20, 60); end
      endcase
      if ($urandom_range(0, 19) == 0) pulse_reset();
      for (int i = 0; i < len; i++)
        drive($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < pt);
    end

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
